// File: rtl/systolic_result_drain_if.sv
// ============================================================================
// systolic_result_drain_if: result-input and element-output handshake bundle.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface systolic_result_drain_if;
    logic         valid_in;
    logic [144:0] matrix_c_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [3:0]   out_index;
    logic         out_last;

    modport master (
        output valid_in, matrix_c_in, out_ready,
        input  out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  valid_in, matrix_c_in, out_ready,
        output out_valid, out_data, out_index, out_last
    );
endinterface

`default_nettype wire

// File: rtl/systolic_result_drain.sv
// ============================================================================
// systolic_result_drain: 2-entry FIFO of 3x3 results streamed one element per
// handshake. Macro DRAIN_SAT_EN saturates elements to unsigned 8 bits. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module systolic_result_drain (
    input  wire logic               clk,
    input  wire logic               reset,
    systolic_result_drain_if.slave  bus,
    output logic                    busy,
    output logic                    overflow
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t       r_state;
    logic [143:0] r_buf [2];
    logic         r_head;
    logic [1:0]   r_count;
    logic [3:0]   r_elem;
    logic         r_overflow;

    logic         w_valid;
    logic         w_last;
    logic         w_hs;
    logic         w_pop;
    logic         w_wr;
    logic         w_tail;
    logic [143:0] w_head_entry;
    logic [7:0]   w_sel;
    logic [15:0]  w_elem;
    logic [15:0]  w_fmt;
    logic         w_unused_msb;

    assign w_valid = (r_state == ST_STREAM);
    assign w_last  = w_valid & (r_elem == 4'd8);
    assign w_hs    = w_valid & bus.out_ready;
    assign w_pop   = w_hs & (r_elem == 4'd8);
    // A full buffer can still take a result in the cycle its head is popped.
    assign w_wr    = bus.valid_in & (~r_count[1] | w_pop);
    // Slot after the current tail; with two entries this wraps onto the head.
    assign w_tail  = r_head ^ r_count[0];

    assign w_unused_msb = bus.matrix_c_in[144];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_elem     <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.valid_in && !w_wr) begin
                r_overflow <= 1'b1;
            end
            if (w_hs) begin
                r_elem <= w_pop ? 4'd0 : r_elem + 4'd1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                ST_IDLE: begin
                    if (w_wr) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_pop && !w_wr && (r_count == 2'd1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_wr) begin
            r_buf[w_tail] <= bus.matrix_c_in[143:0];
        end
    end

    assign w_head_entry = r_buf[r_head];
    assign w_sel        = {r_elem, 4'b0000};
    assign w_elem       = w_head_entry[w_sel +: 16];

`ifdef DRAIN_SAT_EN
    assign w_fmt = (|w_elem[15:8]) ? 16'h00FF : {8'h00, w_elem[7:0]};
`else
    assign w_fmt = w_elem;
`endif

    // Masking keeps out_data at zero while empty, including straight out of reset.
    assign bus.out_data  = w_valid ? w_fmt : 16'h0000;
    assign bus.out_valid = w_valid;
    assign bus.out_index = r_elem;
    assign bus.out_last  = w_last;
    assign busy          = w_valid;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
// ============================================================================
// tb_systolic_result_drain: scoreboard bench for systolic_result_drain.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_result_drain;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic overflow;

    always #5 clk = ~clk;

    systolic_result_drain_if bus();

    systolic_result_drain dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .busy     (busy),
        .overflow (overflow)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] fmt(input logic [15:0] v);
`ifdef DRAIN_SAT_EN
        return (v > 16'd255) ? 16'h00FF : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [144:0] pack9(input logic [15:0] base);
        logic [144:0] m;
        m = '0;
        for (int k = 0; k < 9; k++) m[16*k +: 16] = base + 16'(k);
        m[144] = 1'b1;
        return m;
    endfunction

    task automatic push_exp(input logic [144:0] m);
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            e.data = fmt(m[16*k +: 16]);
            e.idx  = 4'(k);
            e.last = (k == 8);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.valid_in = 1'b1;
        bus.matrix_c_in = pack9(16'h0055);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        checks++; if (bus.out_index !== 4'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", bus.out_index); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignored_valid got %b want 0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        exp_t e;
        bus.matrix_c_in = pack9(16'd1);
        push_exp(bus.matrix_c_in);
        bus.valid_in = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL single_valid cycle %0d got %b want 1", cyc, bus.out_valid);
            end else begin
                e = sb[0];
                if ({bus.out_data, bus.out_index, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL single_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                end
                if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
                void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_timeout remaining %0d want 0", sb.size()); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b valid=%b want 0 0", busy, bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        exp_t e;
        bus.matrix_c_in = pack9(16'd1);
        push_exp(bus.matrix_c_in);
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_valid cycle %0d got %b want 1", cyc, bus.out_valid);
            end else begin
                e = sb[0];
                if ({bus.out_data, bus.out_index, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL stall_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                end
                if (bus.out_ready) void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_timeout remaining %0d want 0", sb.size()); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            bus.matrix_c_in = pack9(16'(16'h10 * (r + 1)));
            if (r < 2) push_exp(bus.matrix_c_in);
            bus.valid_in = 1'b1;
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow got %b want 1", overflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_valid cycle %0d got %b want 1", cyc, bus.out_valid);
            end else begin
                e = sb[0];
                if ({bus.out_data, bus.out_index, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL b2b_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                end
                void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_timeout remaining %0d want 0", sb.size()); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drained busy got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_coincident();
        exp_t e;
        bit   injected;
        do_reset();
        bus.out_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            bus.matrix_c_in = pack9(16'(16'h40 + 16'h10 * r));
            push_exp(bus.matrix_c_in);
            bus.valid_in = 1'b1;
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        bus.out_ready = 1'b1;
        injected = 1'b0;
        for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
            bus.valid_in = 1'b0;
            if (bus.out_last && !injected) begin
                bus.matrix_c_in = pack9(16'h0060);
                push_exp(bus.matrix_c_in);
                bus.valid_in = 1'b1;
                injected = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL full_valid cycle %0d got %b want 1", cyc, bus.out_valid);
            end else begin
                e = sb[0];
                if ({bus.out_data, bus.out_index, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL full_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                end
                void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        checks++; if (sb.size() != 0 || !injected) begin errors++; $display("FAIL full_timeout remaining %0d injected %b want 0 1", sb.size(), injected); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b want 0", overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        bus.matrix_c_in = pack9(16'h0070);
        bus.valid_in = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_valid valid=%b busy=%b want 0 0", bus.out_valid, busy); end
        checks++; if (bus.out_index !== 4'd0) begin errors++; $display("FAIL midreset_index got %0d want 0", bus.out_index); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [144:0] m;
        m = pack9(16'd2);
        m[15:0]  = 16'h012C;
        m[31:16] = 16'h00C8;
        m[47:32] = 16'hFFFF;
        m[63:48] = 16'h00FF;
        m[79:64] = 16'h0100;
        bus.matrix_c_in = m;
        push_exp(m);
        bus.valid_in = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL sat_valid cycle %0d got %b want 1", cyc, bus.out_valid);
            end else begin
                e = sb[0];
                if ({bus.out_data, bus.out_index, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL sat_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                             bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                end
                void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sat_timeout remaining %0d want 0", sb.size()); end
    endtask

    initial begin
        reset = 1'b0;
        bus.valid_in = 1'b0;
        bus.matrix_c_in = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_full_coincident();
        test_reset_midstream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 valid_in  input  1  one-cycle strobe from the 3x3 array: matrix_c_in holds a completed result.
REQ-004 matrix_c_in  input  145  array result; element k (k=0..8, row-major C00..C22) = bits [16k+15:16k]; bit 144 ignored.
REQ-005 out_valid  output  1  out_data holds a valid element.
REQ-006 out_ready  input  1  consumer accepts element when out_valid & out_ready.
REQ-007 out_data  output  16  current element.
REQ-008 out_index  output  4  index k (0..8) of current element.
REQ-009 out_last  output  1  high with element k=8.
REQ-010 busy  output  1  high while any result is buffered.
REQ-011 overflow  output  1  sticky: a result was dropped.

Function
REQ-012 Block SHALL hold a 2-entry result buffer (144 bits each), FIFO order.
REQ-013 On valid_in=1, matrix_c_in[143:0] SHALL be written if occupancy<2, or occupancy=2 and out_last handshake occurs that cycle.
REQ-014 Otherwise the result SHALL be dropped, buffer unchanged, overflow set to 1.
REQ-015 States: IDLE (occupancy 0) and STREAM (occupancy >=1); IDLE->STREAM on accepted write; STREAM->IDLE on out_last handshake with no write that cycle and occupancy 1.
REQ-016 Latency: result accepted at edge N SHALL give out_valid=1, out_index=0 after edge N (visible in cycle N+1) when buffer was empty.
REQ-017 Element counter SHALL advance only on handshake; out_data, out_index stable while out_valid & !out_ready.
REQ-018 On handshake with out_index=8, counter SHALL wrap to 0 and head entry SHALL be popped; next entry (if any) SHALL present element 0 the next cycle with no bubble.
REQ-019 out_valid SHALL equal (occupancy != 0); out_last SHALL equal out_valid & (out_index==8).
REQ-020 busy SHALL equal (occupancy != 0).
REQ-021 Simultaneous write and pop: occupancy SHALL be unchanged; new entry queued behind remaining one.
REQ-022 out_data SHALL be combinationally selected from registered buffer head and registered counter; no combinational path from valid_in or matrix_c_in to any output.

Reset
REQ-023 With reset=0 at a rising edge: occupancy=0, counter=0, state=IDLE, overflow=0.
REQ-024 Resulting outputs: out_valid=0, out_last=0, out_index=0, busy=0, overflow=0, out_data=0.
REQ-025 Reset mid-stream SHALL discard all buffered results; valid_in during reset SHALL be ignored.

Configuration
REQ-026 Macro DRAIN_SAT_EN selects output formatting.
REQ-027 Defined: out_data SHALL be element saturated to unsigned 8 bits (values >255 give 16'h00FF), upper byte 0.
REQ-028 Undefined: out_data SHALL be the raw 16-bit element.

Verification
REQ-029 Reset=0 two cycles, then 1 -> all outputs 0; valid_in held 1 during reset yields nothing.
REQ-030 One result, element k = k+1, out_ready=1 -> out_data 1..9 on 9 consecutive cycles starting cycle after valid_in, out_last only on 9, busy falls after.
REQ-031 Same result, out_ready toggled 1,0,1,0 -> each element held while stalled; sequence 1..9 intact, out_index monotone.
REQ-032 Three back-to-back valid_in (values 0x10+k, 0x20+k, 0x30+k), out_ready=0 -> first two kept, third dropped, overflow=1; release out_ready -> 18 elements, 0x10.. then 0x20.., no bubble between.
REQ-033 Buffer full, valid_in coincident with out_last handshake -> new result accepted, overflow stays 0.
REQ-034 Element 0 = 16'h012C (300), element 1 = 16'h00C8: with DRAIN_SAT_EN -> 16'h00FF, 16'h00C8; without -> 16'h012C, 16'h00C8.
